byte_striping_param: RTL

BYTE_STRIPING_PARAM -- requirements
Module: byte_striping_param

---
 rtl/striping_pkg.sv | 20 ++
 rtl/striping_next_lane.sv | 47 ++++
 rtl/byte_striping_param.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/striping_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : striping_pkg
//  Description : Shared defaults, lane-index width and lane-index type for
//                the byte striping block.
//  Revision    : 1.0 - initial release
// ============================================================================
package striping_pkg;

    localparam int c_LANES_DEFAULT = 4;
    localparam int c_WIDTH_DEFAULT = 8;

    // Sized for the largest supported lane count so one type serves all builds
    localparam int c_LANES_MAX = 8;
    localparam int c_IDX_W     = $clog2(c_LANES_MAX);

    typedef logic [c_IDX_W-1:0] lane_idx_t;

endpackage : striping_pkg
`default_nettype wire

// File: rtl/striping_next_lane.sv
`default_nettype none
// ============================================================================
//  Module      : striping_next_lane
//  Description : Combinational lane walker. From a lane mask and the current
//                lane it finds the next higher enabled lane, whether the
//                current lane is the last enabled one, and the lowest
//                enabled lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module striping_next_lane
    import striping_pkg::*;
#(
    parameter int LANES = c_LANES_DEFAULT
) (
    input  logic [LANES-1:0] i_mask,
    input  lane_idx_t        i_cur,
    output lane_idx_t        o_next,
    output logic             o_is_last,
    output lane_idx_t        o_lowest
);

    // Lowest set bit; scanning downward lets the smallest index win.
    // Kept separate from the walk below because the walk's current lane
    // may itself be derived from this result.
    always_comb begin
        o_lowest = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_lowest = lane_idx_t'(i);
            end
        end
    end

    // Nearest enabled lane above the current one; none means current is last
    always_comb begin
        o_next    = i_cur;
        o_is_last = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_cur))) begin
                o_next    = lane_idx_t'(i);
                o_is_last = 1'b0;
            end
        end
    end

endmodule : striping_next_lane
`default_nettype wire

// File: rtl/byte_striping_param.sv
`default_nettype none
// ============================================================================
//  Module      : byte_striping_param
//  Description : Collects input words into a group spread across the enabled
//                lanes, then presents the group with a valid/ready handshake.
//                A new group can be collected while the previous one waits;
//                only the completing word stalls.
//                Optional: define BYTE_STRIPING_PARITY_EN to add the per-lane
//                even-parity output stripedPAR.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_striping_param
    import striping_pkg::*;
#(
    parameter int LANES = c_LANES_DEFAULT,
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic                     clk1Mhz,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         byteStripingIN,
    input  logic                     byteStripingINVLD,
    output logic                     byteStripingRDY,
    input  logic [LANES-1:0]         laneEN,
    output logic [LANES*WIDTH-1:0]   stripedLanes,
    output logic [LANES-1:0]         stripedMask,
`ifdef BYTE_STRIPING_PARITY_EN
    output logic [LANES-1:0]         stripedPAR,
`endif
    output logic                     stripedVLD,
    input  logic                     stripedRDY,
    output logic [$clog2(LANES)-1:0] laneIdx
);

    localparam int c_OUT_IDX_W = $clog2(LANES);

    logic [LANES-1:0]       r_mask;
    logic [LANES*WIDTH-1:0] r_buf;
    lane_idx_t              r_idx;
    logic                   r_partial;
    logic [LANES*WIDTH-1:0] r_lanes;
    logic [LANES-1:0]       r_omask;
    logic                   r_vld;

    lane_idx_t              w_idx;
    lane_idx_t              w_next;
    lane_idx_t              w_lowest;
    logic                   w_is_last;
    logic                   w_rdy;
    logic                   w_accept;
    logic [LANES*WIDTH-1:0] w_filled;
    logic [LANES*WIDTH-1:0] w_group;

    striping_next_lane #(
        .LANES (LANES)
    ) u_next_lane (
        .i_mask    (r_mask),
        .i_cur     (w_idx),
        .o_next    (w_next),
        .o_is_last (w_is_last),
        .o_lowest  (w_lowest)
    );

    // An empty buffer always starts at the lowest enabled lane
    assign w_idx = r_partial ? r_idx : w_lowest;

    // Ready depends only on registered state, never on stripedRDY
    assign w_rdy    = (r_mask != '0) && !(r_vld && w_is_last);
    assign w_accept = byteStripingINVLD && w_rdy;

    // Buffer with this cycle's word written into its lane
    always_comb begin
        w_filled = r_buf;
        if (w_accept) begin
            w_filled[int'(w_idx)*WIDTH +: WIDTH] = byteStripingIN;
        end
    end

    // Completed group with disabled lanes forced to zero
    always_comb begin
        w_group = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_mask[i]) begin
                w_group[i*WIDTH +: WIDTH] = w_filled[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef BYTE_STRIPING_PARITY_EN
    logic [LANES-1:0] r_par;
    logic [LANES-1:0] w_par;

    // Disabled lanes are already zero in w_group, so their parity is zero
    always_comb begin
        w_par = '0;
        for (int i = 0; i < LANES; i++) begin
            w_par[i] = ^w_group[i*WIDTH +: WIDTH];
        end
    end

    // Parity registers alongside the lane data
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            r_par <= '0;
        end else if (w_accept && w_is_last) begin
            r_par <= w_par;
        end
    end

    assign stripedPAR = r_par;
`endif

    // Collection, group hand-off and output handshake
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            r_mask    <= '0;
            r_buf     <= '0;
            r_idx     <= '0;
            r_partial <= 1'b0;
            r_lanes   <= '0;
            r_omask   <= '0;
            r_vld     <= 1'b0;
        end else begin
            if (r_vld && stripedRDY) begin
                r_vld <= 1'b0;
            end
            if (w_accept) begin
                if (w_is_last) begin
                    // Completion only happens with the output slot free
                    r_lanes   <= w_group;
                    r_omask   <= r_mask;
                    r_vld     <= 1'b1;
                    r_buf     <= '0;
                    r_idx     <= '0;
                    r_partial <= 1'b0;
                    r_mask    <= laneEN;
                end else begin
                    r_buf     <= w_filled;
                    r_idx     <= w_next;
                    r_partial <= 1'b1;
                end
            end else if (!r_partial) begin
                // Mask tracks laneEN only while no group is in progress
                r_mask <= laneEN;
            end
        end
    end

    assign byteStripingRDY = w_rdy;
    assign stripedLanes    = r_lanes;
    assign stripedMask     = r_omask;
    assign stripedVLD      = r_vld;
    assign laneIdx         = w_idx[c_OUT_IDX_W-1:0];

endmodule : byte_striping_param
`default_nettype wire
